perf_counter_bank: RTL



---
 rtl/perf_counter_bank.sv | 134 +++++++++++++
 1 files changed

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: one cycle counter plus NUM_COUNTERS-1 event counters.
// Counting is enabled only inside a PC-triggered window (START_PC .. FINAL_PC).
// Counters saturate and raise sticky overflow flags. A registered nibble
// readout port serves the VGA digit overlay.
//
// Optional build macro: PERF_SNAPSHOT_EN. When defined, snap_req copies all
// counters into a snapshot bank and readout sources that bank. When undefined,
// snap_req is ignored and readout sources the live counters.
//
// Ports:
//   cpu_clk    clock, all state on rising edge
//   resetN     asynchronous active-low reset
//   pc         current program counter
//   event_in   per-counter event strobes (bit 0 ignored, counter 0 counts cycles)
//   clear      synchronous clear of counters, flags and FSM
//   rd_sel     counter selected for readout
//   rd_nibble  nibble index within the selected counter, 0 = LSN
//   rd_data    selected nibble, one cycle latency
//   state      FSM state: 0 IDLE, 1 RUNNING, 2 DONE
//   overflow   sticky saturation flags, one per counter
//   snap_req   snapshot strobe (only with PERF_SNAPSHOT_EN)
module perf_counter_bank #(
  parameter int unsigned NUM_COUNTERS  = 4,
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter logic [15:0] START_PC      = 16'h0000,
  parameter logic [15:0] FINAL_PC      = 16'hFFFF,
  parameter int unsigned NIBBLE_IDX_W  = 4
) (
  input  logic                            cpu_clk,
  input  logic                            resetN,
  input  logic [15:0]                     pc,
  input  logic [NUM_COUNTERS-1:0]         event_in,
  input  logic                            clear,
  input  logic [$clog2(NUM_COUNTERS)-1:0] rd_sel,
  input  logic [NIBBLE_IDX_W-1:0]         rd_nibble,
  output logic [3:0]                      rd_data,
  output logic [1:0]                      state,
  output logic [NUM_COUNTERS-1:0]         overflow,
  input  logic                            snap_req
);

  localparam int unsigned SEL_W = $clog2(NUM_COUNTERS);
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  state_e                   st;
  logic [COUNTER_WIDTH-1:0] cnt [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0]  inc_c;
  logic                     sel_ok_c;
  logic [COUNTER_WIDTH-1:0] src_c;
  logic                     unused_ev0;

  assign state      = st;
  assign unused_ev0 = event_in[0];

  // Window FSM; the unreachable encoding 3 behaves like IDLE.
  always_ff @(posedge cpu_clk or negedge resetN) begin
    if (!resetN) begin
      st <= ST_IDLE;
    end else if (clear) begin
      st <= ST_IDLE;
    end else begin
      case (st)
        ST_IDLE:    if (pc == START_PC) st <= ST_RUNNING;
        ST_RUNNING: if (pc == FINAL_PC) st <= ST_DONE;
        ST_DONE:    st <= ST_DONE;
        default:    st <= (pc == START_PC) ? ST_RUNNING : ST_IDLE;
      endcase
    end
  end

  // Increment requests: counter 0 every enabled cycle, others on their event.
  assign inc_c = {NUM_COUNTERS{st == ST_RUNNING}} & {event_in[NUM_COUNTERS-1:1], 1'b1};

  // Saturating counters with sticky overflow.
  always_ff @(posedge cpu_clk or negedge resetN) begin
    if (!resetN) begin
      for (int unsigned i = 0; i < NUM_COUNTERS; i++) cnt[i] <= '0;
      overflow <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < NUM_COUNTERS; i++) cnt[i] <= '0;
      overflow <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
        if (inc_c[i]) begin
          if (cnt[i] == CNT_MAX) overflow[i] <= 1'b1;
          else                   cnt[i] <= cnt[i] + COUNTER_WIDTH'(1);
        end
      end
    end
  end

  assign sel_ok_c = (32'(rd_sel) < NUM_COUNTERS);

`ifdef PERF_SNAPSHOT_EN
  logic [COUNTER_WIDTH-1:0] snap [NUM_COUNTERS];

  // Snapshot bank captures pre-update counter values; clear wins over snap_req.
  always_ff @(posedge cpu_clk or negedge resetN) begin
    if (!resetN) begin
      for (int unsigned i = 0; i < NUM_COUNTERS; i++) snap[i] <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < NUM_COUNTERS; i++) snap[i] <= '0;
    end else if (snap_req) begin
      for (int unsigned i = 0; i < NUM_COUNTERS; i++) snap[i] <= cnt[i];
    end
  end

  always_comb begin
    src_c = '0;
    if (sel_ok_c) src_c = snap[rd_sel[SEL_W-1:0]];
  end
`else
  logic unused_snap;
  assign unused_snap = snap_req;

  always_comb begin
    src_c = '0;
    if (sel_ok_c) src_c = cnt[rd_sel[SEL_W-1:0]];
  end
`endif

  // Shifting past the counter width yields 0 for out-of-range nibble indices.
  always_ff @(posedge cpu_clk or negedge resetN) begin
    if (!resetN) rd_data <= 4'h0;
    else         rd_data <= 4'(src_c >> {rd_nibble, 2'b00});
  end

endmodule
